// File: rtl/rx_os_count_sequencer.sv
// Receive ordered-set count sequencer: clears the osChecker bank, counts consecutive
// matching ordered sets per active lane and reports success or timeout with a done pulse.
module rx_os_count_sequencer #(
  parameter int unsigned LANES = 16,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned TMR_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       numberOfDetectedLanes,
  input  logic [CNT_W-1:0] targetCount,
  input  logic [TMR_W-1:0] timeoutCycles,
  input  logic [LANES-1:0] countUp,
  input  logic [LANES-1:0] resetCounters,
  output logic [LANES-1:0] resetOsCheckers,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic             timedOut,
  output logic [LANES-1:0] laneMet
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_target;
  logic [TMR_W-1:0] r_tmo_cfg;
  logic [LANES-1:0] r_mask;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt [LANES];
  logic [LANES-1:0] r_lane_met;

  logic [LANES-1:0] r_rst_chk;
  logic             r_busy;
  logic             r_done;
  logic             r_success;
  logic             r_timed_out;

  int unsigned      w_n;
  logic [LANES-1:0] w_mask;
  logic [CNT_W-1:0] w_cnt_nxt [LANES];
  logic [LANES-1:0] w_met_nxt;
  logic             w_all_met;
  logic             w_expired;
  logic [LANES-1:0] w_rst_chk;
  logic             w_busy;
  logic             w_done;
  logic             w_success;
  logic             w_timed_out;

  // Lane count clamp (0 -> 1, above bank size -> bank size) and contiguous active mask
  always_comb begin
    w_n = 32'(numberOfDetectedLanes);
    if (w_n == 0) begin
      w_n = 1;
    end else if (w_n > LANES) begin
      w_n = LANES;
    end
    w_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_mask[i] = (i < w_n);
    end
  end

  // Per-lane counter update: mismatch beats match, saturate at max, inactive lanes pinned to 0
  always_comb begin
    w_met_nxt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (!r_mask[i] || resetCounters[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (countUp[i] && (r_cnt[i] != CNT_MAX)) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
      w_met_nxt[i] = r_mask[i] && (w_cnt_nxt[i] >= r_target);
    end
  end

  assign w_all_met = ((r_lane_met & r_mask) == r_mask);
  assign w_expired = (r_timer == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    w_next      = r_state;
    w_success   = r_success;
    w_timed_out = r_timed_out;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ARM;
      S_ARM:   w_next = S_COUNT;
      S_COUNT: if (w_all_met || w_expired) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
    end
    if (w_next == S_ARM) begin
      w_success   = 1'b0;
      w_timed_out = 1'b0;
    end
    if ((r_state == S_COUNT) && (w_next == S_DONE)) begin
      w_success   = w_all_met;
      w_timed_out = !w_all_met;
    end
    if (abort) begin
      w_success   = 1'b0;
      w_timed_out = 1'b0;
    end
    w_done    = (w_next == S_DONE);
    w_busy    = (w_next != S_IDLE);
    w_rst_chk = (w_next == S_COUNT) ? ~r_mask : '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rst_chk   <= '1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_success   <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_rst_chk   <= w_rst_chk;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_success   <= w_success;
      r_timed_out <= w_timed_out;
    end
  end

  // Configuration latch, counters and timer; results freeze once COUNT is left
  always_ff @(posedge clk) begin
    if (reset) begin
      r_target   <= '0;
      r_tmo_cfg  <= '0;
      r_mask     <= '0;
      r_timer    <= '0;
      r_lane_met <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if ((r_state == S_IDLE) && start && !abort) begin
        r_target  <= (targetCount == '0) ? CNT_W'(1) : targetCount;
        r_tmo_cfg <= timeoutCycles;
        r_mask    <= w_mask;
      end
      if (abort || (r_state == S_ARM)) begin
        r_lane_met <= '0;
        for (int unsigned i = 0; i < LANES; i++) begin
          r_cnt[i] <= '0;
        end
        if (!abort) begin
          r_timer <= r_tmo_cfg;
        end
      end else if ((r_state == S_COUNT) && (w_next == S_COUNT)) begin
        r_timer    <= r_timer - TMR_W'(1);
        r_lane_met <= w_met_nxt;
        for (int unsigned i = 0; i < LANES; i++) begin
          r_cnt[i] <= w_cnt_nxt[i];
        end
      end
    end
  end

  assign resetOsCheckers = r_rst_chk;
  assign busy            = r_busy;
  assign done            = r_done;
  assign success         = r_success;
  assign timedOut        = r_timed_out;
  assign laneMet         = r_lane_met;

endmodule

// File: tb/tb_rx_os_count_sequencer.sv
// Bench for rx_os_count_sequencer: cycle model compared every cycle, plus directed
// scenarios with hand-computed latencies and result flags.
module tb_rx_os_count_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  numberOfDetectedLanes;
  logic [4:0]  targetCount;
  logic [23:0] timeoutCycles;
  logic [15:0] countUp;
  logic [15:0] resetCounters;
  logic [15:0] resetOsCheckers;
  logic        busy;
  logic        done;
  logic        success;
  logic        timedOut;
  logic [15:0] laneMet;

  rx_os_count_sequencer #(.LANES(16), .CNT_W(5), .TMR_W(24)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .abort                (abort),
    .numberOfDetectedLanes(numberOfDetectedLanes),
    .targetCount          (targetCount),
    .timeoutCycles        (timeoutCycles),
    .countUp              (countUp),
    .resetCounters        (resetCounters),
    .resetOsCheckers      (resetOsCheckers),
    .busy                 (busy),
    .done                 (done),
    .success              (success),
    .timedOut             (timedOut),
    .laneMet              (laneMet)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 arm, 2 count, 3 done
  int          m_ph = 0;
  int          m_cnt [16];
  int          m_tgt = 1;
  int          m_n = 1;
  int          m_tmo = 0;
  int          m_timer = 0;
  logic [15:0] m_met = '0;
  logic [15:0] m_rst = 16'hFFFF;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_succ = 1'b0;
  logic        m_to = 1'b0;

  function automatic logic [15:0] lanes_mask(input int n);
    return 16'((32'h1 << n) - 1);
  endfunction

  always @(posedge clk) begin
    bit all_met;
    if (reset) begin
      m_ph = 0;
      m_met = '0;
      m_succ = 1'b0;
      m_to = 1'b0;
      m_timer = 0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else if (abort) begin
      m_ph = 0;
      m_met = '0;
      m_succ = 1'b0;
      m_to = 1'b0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_tgt = (targetCount == 0) ? 1 : int'(targetCount);
          m_n   = (numberOfDetectedLanes == 0) ? 1 :
                  (numberOfDetectedLanes > 16) ? 16 : int'(numberOfDetectedLanes);
          m_tmo = int'(timeoutCycles);
          m_succ = 1'b0;
          m_to = 1'b0;
          m_ph = 1;
        end
        1: begin
          for (int i = 0; i < 16; i++) m_cnt[i] = 0;
          m_met = '0;
          m_timer = m_tmo;
          m_ph = 2;
        end
        2: begin
          all_met = 1'b1;
          for (int i = 0; i < m_n; i++) if (!m_met[i]) all_met = 1'b0;
          if (all_met) begin
            m_ph = 3; m_succ = 1'b1; m_to = 1'b0;
          end else if (m_timer == 0) begin
            m_ph = 3; m_succ = 1'b0; m_to = 1'b1;
          end else begin
            m_timer = m_timer - 1;
            for (int i = 0; i < 16; i++) begin
              if (i >= m_n || resetCounters[i]) m_cnt[i] = 0;
              else if (countUp[i] && m_cnt[i] < 31) m_cnt[i] = m_cnt[i] + 1;
              m_met[i] = (i < m_n) && (m_cnt[i] >= m_tgt);
            end
          end
        end
        default: m_ph = 0;
      endcase
    end
    m_done = (m_ph == 3);
    m_busy = (m_ph != 0);
    m_rst  = (m_ph == 2) ? ~lanes_mask(m_n) : 16'hFFFF;
  end

  // Every-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    #2;
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_success", 32'(success), 32'(m_succ));
    chk("m_timedOut", 32'(timedOut), 32'(m_to));
    chk("m_laneMet", 32'(laneMet), 32'(m_met));
    chk("m_resetOsCheckers", 32'(resetOsCheckers), 32'(m_rst));
  end

  int          t0;
  bit          got_done;
  int          done_cyc;
  logic        d_succ;
  logic        d_to;
  logic [15:0] d_met;

  task automatic step(input logic [15:0] cu, input logic [15:0] rc, input logic ab, input logic st);
    @(negedge clk);
    if (done === 1'b1 && !got_done) begin
      got_done = 1'b1;
      done_cyc = cyc;
      d_succ = success;
      d_to = timedOut;
      d_met = laneMet;
    end
    countUp = cu;
    resetCounters = rc;
    abort = ab;
    start = st;
  endtask

  task automatic do_start(input logic [4:0] n, input logic [4:0] tgt, input logic [23:0] tmo);
    @(negedge clk);
    numberOfDetectedLanes = n;
    targetCount = tgt;
    timeoutCycles = tmo;
    countUp = '0;
    resetCounters = '0;
    abort = 1'b0;
    start = 1'b1;
    t0 = cyc;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_cu(input logic [15:0] cu, input int budget);
    for (int k = 0; k < budget && !got_done; k++) step(cu, '0, 1'b0, 1'b0);
    chk("done_seen", 32'(got_done), 32'd1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    numberOfDetectedLanes = '0;
    targetCount = '0;
    timeoutCycles = '0;
    countUp = '0;
    resetCounters = '0;
    got_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rst", 32'(resetOsCheckers), 32'hFFFF);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_laneMet", 32'(laneMet), 32'd0);
    reset = 1'b0;
    step('0, '0, 1'b0, 1'b0);

    // Basic pass
    do_start(5'd4, 5'd8, 24'd1000);
    run_cu(16'h000F, 40);
    chk("basic_latency", 32'(done_cyc - t0), 32'd11);
    chk("basic_success", 32'(d_succ), 32'd1);
    chk("basic_timedOut", 32'(d_to), 32'd0);
    chk("basic_laneMet", 32'(d_met), 32'h000F);
    chk("basic_laneMet_held", 32'(laneMet), 32'h000F);

    // Mismatch restart at t+7 (reset beats countUp)
    do_start(5'd1, 5'd8, 24'd1000);
    repeat (5) step(16'h0001, '0, 1'b0, 1'b0);
    step(16'h0001, 16'h0001, 1'b0, 1'b0);
    run_cu(16'h0001, 40);
    chk("restart_latency", 32'(done_cyc - t0), 32'd17);
    chk("restart_success", 32'(d_succ), 32'd1);

    // Timeout: only lane 0 of 2 counts
    do_start(5'd2, 5'd8, 24'd20);
    run_cu(16'h0001, 60);
    chk("timeout_latency", 32'(done_cyc - t0), 32'd23);
    chk("timeout_success", 32'(d_succ), 32'd0);
    chk("timeout_timedOut", 32'(d_to), 32'd1);
    chk("timeout_laneMet", 32'(d_met), 32'h0001);

    // Target reached in the same cycle the timer expires
    do_start(5'd1, 5'd8, 24'd8);
    run_cu(16'h0001, 40);
    chk("simul_latency", 32'(done_cyc - t0), 32'd11);
    chk("simul_success", 32'(d_succ), 32'd1);
    chk("simul_timedOut", 32'(d_to), 32'd0);

    // N=0, target=0 -> single lane, single countUp
    do_start(5'd0, 5'd0, 24'd100);
    step(16'h0001, '0, 1'b0, 1'b0);
    run_cu('0, 20);
    chk("clamp0_latency", 32'(done_cyc - t0), 32'd4);
    chk("clamp0_success", 32'(d_succ), 32'd1);

    // N=20 -> all 16 lanes active
    do_start(5'd20, 5'd1, 24'd100);
    step(16'hFFFF, '0, 1'b0, 1'b0);
    chk("clamp20_rst", 32'(resetOsCheckers), 32'h0000);
    run_cu('0, 20);
    chk("clamp20_latency", 32'(done_cyc - t0), 32'd4);
    chk("clamp20_laneMet", 32'(d_met), 32'hFFFF);

    // N=3, nothing counts, short timeout
    do_start(5'd3, 5'd8, 24'd3);
    step('0, '0, 1'b0, 1'b0);
    chk("n3_rst", 32'(resetOsCheckers), 32'hFFF8);
    run_cu('0, 20);
    chk("n3_latency", 32'(done_cyc - t0), 32'd6);
    chk("n3_timedOut", 32'(d_to), 32'd1);

    // Abort mid-COUNT
    do_start(5'd2, 5'd8, 24'd100);
    repeat (3) step(16'h0003, '0, 1'b0, 1'b0);
    step(16'h0003, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rst", 32'(resetOsCheckers), 32'hFFFF);
    chk("abort_success", 32'(success), 32'd0);
    repeat (12) step(16'h0003, '0, 1'b0, 1'b0);
    chk("abort_no_done", 32'(got_done), 32'd0);

    // Synchronous reset mid-COUNT
    do_start(5'd2, 5'd8, 24'd100);
    repeat (3) step(16'h0003, '0, 1'b0, 1'b0);
    reset = 1'b1;
    step('0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("sreset_busy", 32'(busy), 32'd0);
    chk("sreset_rst", 32'(resetOsCheckers), 32'hFFFF);
    chk("sreset_laneMet", 32'(laneMet), 32'd0);
    repeat (12) step(16'h0003, '0, 1'b0, 1'b0);
    chk("sreset_no_done", 32'(got_done), 32'd0);

    // start during COUNT is ignored; target 4 stays latched
    do_start(5'd1, 5'd4, 24'd100);
    step(16'h0001, '0, 1'b0, 1'b0);
    targetCount = 5'd1;
    step(16'h0001, '0, 1'b0, 1'b1);
    run_cu(16'h0001, 40);
    chk("ignstart_latency", 32'(done_cyc - t0), 32'd7);
    chk("ignstart_success", 32'(d_succ), 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
